// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory request path: funct3 encodings, responder
// states and the access legality rule used by both the memory stage and the responder.
package data_mem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int LANE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   // Illegal funct3 for the direction, or a misaligned half/word access.
   function automatic logic access_illegal(input logic       write,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      logic bad;
      case (funct3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = addr_lo[0];
         F3_W:    bad = (addr_lo != 2'b00);
         F3_BU:   bad = write;
         F3_HU:   bad = write | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU memory stage (master) and the RAM responder (slave).
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_addr, req_write, req_funct3, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_addr, req_write, req_funct3, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational byte-lane logic: legality check, store lane mask with replicated data,
// and load extraction with sign/zero extension (little-endian).
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]        addr_lo,
   input  logic              write,
   input  logic [2:0]        funct3,
   input  logic [31:0]       wdata,
   input  logic [31:0]       rword,
   output logic              align_err,
   output logic [LANE_W-1:0] lane_mask,
   output logic [31:0]       wdata_rep,
   output logic [31:0]       load_data
);

   logic [31:0] shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      align_err = access_illegal(write, funct3, addr_lo);
      shifted   = rword >> {addr_lo, 3'b000};
      sel_byte  = shifted[7:0];
      sel_half  = addr_lo[1] ? rword[31:16] : rword[15:0];

      lane_mask = '0;
      wdata_rep = wdata;
      case (funct3)
         F3_B: begin
            lane_mask = LANE_W'(1) << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         F3_H: begin
            lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         F3_W:    lane_mask = 4'b1111;
         default: lane_mask = '0;
      endcase

      case (funct3)
         F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
         F3_W:    load_data = rword;
         F3_BU:   load_data = {24'd0, sel_byte};
         F3_HU:   load_data = {16'd0, sel_half};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// RAM-side responder: one load/store at a time, WAIT_STATES wait cycles, registered-read
// word array, one-cycle completion pulse with formatted load data or an error flag.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t state_reg, state_next;

   logic [3:0]       cnt_reg;
   logic [1:0]       addr_lo_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             write_reg;
   logic [2:0]       f3_reg;
   logic [31:0]      wdata_reg;
   logic             range_err_reg;
   logic [31:0]      rdata_hold_reg;
   logic             error_hold_reg;
   logic [31:0]      rd_word_reg;

   logic [31:0] mem_array [DEPTH_WORDS];

   // Word-offset subtraction with a borrow bit so addresses below BASE_ADDR never wrap
   // (BASE_ADDR is expected to be word aligned).
   logic [30:0] req_word_off;
   logic        req_range_err;
   logic        req_err;
   logic        accept;

   assign req_word_off  = {1'b0, bus.req_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
   assign req_range_err = req_word_off[30] | (req_word_off[29:0] >= 30'(DEPTH_WORDS));
   assign req_err       = req_range_err
                        | access_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
   assign accept        = bus.req_valid & (state_reg == ST_IDLE);

   logic              align_err;
   logic [LANE_W-1:0] lane_mask;
   logic [31:0]       wdata_rep;
   logic [31:0]       load_data;

   mem_lane_align u_align (
      .addr_lo   (addr_lo_reg),
      .write     (write_reg),
      .funct3    (f3_reg),
      .wdata     (wdata_reg),
      .rword     (rd_word_reg),
      .align_err (align_err),
      .lane_mask (lane_mask),
      .wdata_rep (wdata_rep),
      .load_data (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (req_err)               state_next = ST_RESP;
               else if (WAIT_STATES == 0) state_next = ST_ACCESS;
               else                       state_next = ST_WAIT;
            end
         end
         ST_WAIT:   if (cnt_reg == 4'd1) state_next = ST_ACCESS;
         ST_ACCESS: state_next = ST_RESP;
         ST_RESP:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   logic        ready_c, resp_valid_c, mem_we, mem_re, error_now;
   logic [31:0] rdata_now;

   always_comb begin
      ready_c      = (state_reg == ST_IDLE);
      resp_valid_c = (state_reg == ST_RESP);
      mem_we       = (state_reg == ST_ACCESS) &  write_reg;
      mem_re       = (state_reg == ST_ACCESS) & ~write_reg;
      error_now    = range_err_reg | align_err;
      rdata_now    = (error_now | write_reg) ? 32'd0 : load_data;
   end

   // Response fields are live during RESP and held afterwards until the next response.
   assign bus.req_ready  = ready_c;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_rdata = resp_valid_c ? rdata_now : rdata_hold_reg;
   assign bus.resp_error = resp_valid_c ? error_now : error_hold_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg        <= '0;
         addr_lo_reg    <= '0;
         idx_reg        <= '0;
         write_reg      <= 1'b0;
         f3_reg         <= '0;
         wdata_reg      <= '0;
         range_err_reg  <= 1'b0;
         rdata_hold_reg <= '0;
         error_hold_reg <= 1'b0;
      end else begin
         if (accept) begin
            cnt_reg       <= 4'(WAIT_STATES);
            addr_lo_reg   <= bus.req_addr[1:0];
            idx_reg       <= req_word_off[IDX_W-1:0];
            write_reg     <= bus.req_write;
            f3_reg        <= bus.req_funct3;
            wdata_reg     <= bus.req_wdata;
            range_err_reg <= req_range_err;
         end else if (state_reg == ST_WAIT) begin
            cnt_reg <= cnt_reg - 4'd1;
         end
         if (resp_valid_c) begin
            rdata_hold_reg <= rdata_now;
            error_hold_reg <= error_now;
         end
      end
   end

   logic [LANE_W-1:0] lane_we;

   genvar gi;
   generate
      for (gi = 0; gi < LANE_W; gi++) begin : g_lane
         assign lane_we[gi] = mem_we & lane_mask[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANE_W; i++) begin
         if (lane_we[i]) mem_array[idx_reg][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
      if (mem_re) rd_word_reg <= mem_array[idx_reg];
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed and random loads/stores against a byte-addressed model,
// plus reset-mid-operation and back-to-back streaming on a zero-wait-state instance.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam int          WS_A    = 2;
   localparam logic [31:0] BASE_B  = 32'h0000_0100;
   localparam int          DEPTH_B = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS_A), .BASE_ADDR(32'h0)) u_dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   data_mem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_STATES(0), .BASE_ADDR(BASE_B)) u_dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit [7:0] mem_a [longint];
   bit [7:0] mem_b [longint];

   typedef struct { bit w; bit [2:0] f3; bit [31:0] a; bit [31:0] d; } req_t;
   typedef struct { int due; bit e; bit [31:0] r; } exp_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory, access size from funct3, legality/range by plain arithmetic.
   function automatic void model(input int which, input bit w, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] d,
                                 output bit e, output bit [31:0] r);
      longint base, depth, addr, v;
      int     size;
      bit     legal;
      base  = (which == 0) ? 64'd0 : longint'(BASE_B);
      depth = (which == 0) ? 1024 : DEPTH_B;
      addr  = longint'(a);
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e = !legal || (addr % size != 0) || (addr < base) || ((addr - base) / 4 >= depth);
      r = 32'd0;
      if (e) return;
      if (w) begin
         for (int i = 0; i < size; i++) begin
            if (which == 0) mem_a[addr + i] = d[8*i +: 8];
            else            mem_b[addr + i] = d[8*i +: 8];
         end
      end else begin
         v = 0;
         for (int i = 0; i < size; i++) begin
            if (which == 0) v |= longint'(mem_a[addr + i]) << (8 * i);
            else            v |= longint'(mem_b[addr + i]) << (8 * i);
         end
         if (!f3[2] && size < 4 && v[8*size-1]) v -= (longint'(1) << (8 * size));
         r = v[31:0];
      end
   endfunction

   task automatic issue_a(input bit w, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] d, input string tag);
      bit e;
      bit [31:0] r;
      int due, seen;
      model(0, w, f3, a, d, e, r);
      @(negedge clk);
      check({tag, "_ready"}, 32'(bus_a.req_ready), 32'd1);
      bus_a.req_valid  = 1'b1;
      bus_a.req_write  = w;
      bus_a.req_funct3 = f3;
      bus_a.req_addr   = a;
      bus_a.req_wdata  = d;
      @(posedge clk);
      #1 bus_a.req_valid = 1'b0;
      due  = e ? 1 : WS_A + 2;
      seen = 0;
      for (int k = 1; k <= due + 2; k++) begin
         @(negedge clk);
         if (bus_a.resp_valid === 1'b1) begin
            seen++;
            if (seen == 1) begin
               check({tag, "_lat"}, 32'(k), 32'(due));
               check({tag, "_rdata"}, bus_a.resp_rdata, r);
               check({tag, "_err"}, 32'(bus_a.resp_error), 32'(e));
            end
         end
      end
      check({tag, "_pulses"}, 32'(seen), 32'd1);
      $display("tb: %s w=%0b f3=%0d addr=%h wdata=%h -> exp err=%0b rdata=%h",
               tag, w, f3, a, d, e, r);
   endtask

   task automatic stream_b();
      req_t reqs[$];
      exp_t exp_q[$];
      exp_t x;
      req_t q;
      bit   e;
      bit [31:0] r;
      int   cyc, idx, last_acc, gap_exp;
      bit   due_now;
      for (int i = 0; i < 8; i++) reqs.push_back('{1'b1, F3_W, BASE_B + 32'(4 * i), $urandom});
      reqs.push_back('{1'b1, F3_W, 32'h0000_01FC, 32'hCAFE_F00D});
      reqs.push_back('{1'b0, F3_W, 32'h0000_01FC, 32'h0});
      reqs.push_back('{1'b0, F3_W, 32'h0000_0200, 32'h0});
      reqs.push_back('{1'b0, F3_B, 32'h0000_00FC, 32'h0});
      for (int i = 0; i < 16; i++)
         reqs.push_back('{1'($urandom), 3'($urandom_range(0, 7)),
                          BASE_B + 32'($urandom_range(0, 31)), $urandom});
      idx = 0; cyc = 0; last_acc = -1; gap_exp = 0;
      @(negedge clk);
      bus_b.req_valid  = 1'b1;
      bus_b.req_write  = reqs[0].w;
      bus_b.req_funct3 = reqs[0].f3;
      bus_b.req_addr   = reqs[0].a;
      bus_b.req_wdata  = reqs[0].d;
      while ((idx < reqs.size() || exp_q.size() > 0) && cyc < 2000) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("b_valid", 32'(bus_b.resp_valid), 32'(due_now));
         if (due_now) begin
            x = exp_q.pop_front();
            check("b_rdata", bus_b.resp_rdata, x.r);
            check("b_err", 32'(bus_b.resp_error), 32'(x.e));
         end
         if (idx < reqs.size() && bus_b.req_ready === 1'b1) begin
            if (last_acc >= 0) check("b_gap", 32'(cyc - last_acc), 32'(gap_exp));
            q = reqs[idx];
            model(1, q.w, q.f3, q.a, q.d, e, r);
            exp_q.push_back('{cyc + (e ? 1 : 2), e, r});
            gap_exp  = e ? 2 : 3;
            last_acc = cyc;
            $display("tb: b_req w=%0b f3=%0d addr=%h wdata=%h -> exp err=%0b rdata=%h",
                     q.w, q.f3, q.a, q.d, e, r);
            @(posedge clk);
            #1;
            idx++;
            if (idx < reqs.size()) begin
               bus_b.req_write  = reqs[idx].w;
               bus_b.req_funct3 = reqs[idx].f3;
               bus_b.req_addr   = reqs[idx].a;
               bus_b.req_wdata  = reqs[idx].d;
            end else begin
               bus_b.req_valid = 1'b0;
            end
         end
      end
      check("b_drained", 32'(exp_q.size()), 32'd0);
      check("b_all_issued", 32'(idx), 32'(reqs.size()));
   endtask

   initial begin
      int seen;
      bit e;
      bit [31:0] r;
      bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_funct3 = '0;
      bus_a.req_addr  = '0;   bus_a.req_wdata = '0;
      bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_funct3 = '0;
      bus_b.req_addr  = '0;   bus_b.req_wdata = '0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus_a.req_ready), 32'd1);
      check("rst_valid", 32'(bus_a.resp_valid), 32'd0);
      check("rst_rdata", bus_a.resp_rdata, 32'd0);
      check("rst_err", 32'(bus_a.resp_error), 32'd0);
      check("rst_ready_b", 32'(bus_b.req_ready), 32'd1);
      rst = 1'b0;

      issue_a(1'b1, F3_W,  32'h10, 32'hDEADBEEF, "sw10");
      issue_a(1'b0, F3_W,  32'h10, 32'h0, "lw10");
      issue_a(1'b1, F3_B,  32'h11, 32'h0000_0080, "sb11");
      issue_a(1'b0, F3_B,  32'h11, 32'h0, "lb11");
      issue_a(1'b0, F3_BU, 32'h11, 32'h0, "lbu11");
      issue_a(1'b0, F3_W,  32'h10, 32'h0, "lw10b");
      issue_a(1'b1, F3_H,  32'h12, 32'h5555_1234, "sh12");
      issue_a(1'b0, F3_H,  32'h12, 32'h0, "lh12");
      issue_a(1'b1, F3_H,  32'h12, 32'h0000_8001, "sh12b");
      issue_a(1'b0, F3_HU, 32'h12, 32'h0, "lhu12");
      issue_a(1'b0, F3_H,  32'h12, 32'h0, "lh12b");
      issue_a(1'b0, F3_W,  32'h13, 32'h0, "e_lw13");
      issue_a(1'b1, F3_H,  32'h11, 32'hFFFF_FFFF, "e_sh11");
      issue_a(1'b0, F3_B,  32'h1000, 32'h0, "e_lb1000");
      issue_a(1'b0, 3'b011, 32'h10, 32'h0, "e_f3_011");
      issue_a(1'b1, F3_BU, 32'h10, 32'hFFFF_FFFF, "e_sf3_100");
      issue_a(1'b1, F3_W,  32'hFFFF_FFFC, 32'h0, "e_swtop");
      issue_a(1'b0, F3_W,  32'h10, 32'h0, "lw10_after_err");
      issue_a(1'b1, F3_W,  32'hFFC, 32'hCAFE_F00D, "sw_last");
      issue_a(1'b0, F3_W,  32'hFFC, 32'h0, "lw_last");

      // Reset during WAIT drops the pending store and its response.
      issue_a(1'b1, F3_W, 32'h20, 32'h1111_1111, "sw20");
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_funct3 = F3_W;
      bus_a.req_addr  = 32'h20; bus_a.req_wdata = 32'h2222_2222;
      @(posedge clk);
      #1 bus_a.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rw_ready", 32'(bus_a.req_ready), 32'd1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus_a.resp_valid === 1'b1) seen++;
      end
      check("rw_no_resp", 32'(seen), 32'd0);
      $display("tb: reset during WAIT on store to 00000020");
      issue_a(1'b0, F3_W, 32'h20, 32'h0, "lw20_dropped");

      // Reset during RESP truncates the pulse but keeps the committed store.
      model(0, 1'b1, F3_W, 32'h24, 32'h3333_3333, e, r);
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_funct3 = F3_W;
      bus_a.req_addr  = 32'h24; bus_a.req_wdata = 32'h3333_3333;
      @(posedge clk);
      #1 bus_a.req_valid = 1'b0;
      repeat (WS_A + 2) @(negedge clk);
      check("rr_valid", 32'(bus_a.resp_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rr_trunc", 32'(bus_a.resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("tb: reset during RESP on store to 00000024");
      issue_a(1'b0, F3_W, 32'h24, 32'h0, "lw24_kept");

      for (int i = 0; i < 16; i++) issue_a(1'b1, F3_W, 32'h40 + 32'(4 * i), $urandom, "init");
      for (int i = 0; i < 40; i++) begin
         int sel;
         bit [31:0] a;
         sel = $urandom_range(0, 7);
         if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 15));
         else if (sel == 1) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else               a = 32'h40 + 32'($urandom_range(0, 63));
         issue_a(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, "rnd");
      end

      stream_b();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
